// File: rtl/alu_exec.sv
// Execute-stage ALU: registered result/flags with a valid pulse, owns HI/LO and the halt flag.
// Define ALU_EXEC_FAST_MUL_EN for a single-cycle combinational multiply; default is a 33-cycle shift-add multiplier.
module alu_exec #(
    parameter int MUL_STEPS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [4:0]  ALUop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        valid_out,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        halt
);

    localparam logic [4:0] OP_SLL  = 5'd0,  OP_SRL  = 5'd1,  OP_SRA  = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3,  OP_ADDU = 5'd4,  OP_SUB  = 5'd5,  OP_SUBU = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7,  OP_OR   = 5'd8,  OP_XOR  = 5'd9,  OP_NOR  = 5'd10;
    localparam logic [4:0] OP_SLT  = 5'd11, OP_SLTU = 5'd12, OP_LUI  = 5'd13;
    localparam logic [4:0] OP_MFHI = 5'd14, OP_MFLO = 5'd15, OP_MTHI = 5'd16, OP_MTLO = 5'd17;
    localparam logic [4:0] OP_MULT = 5'd18, OP_MUL  = 5'd19, OP_HALT = 5'd20;

    logic [31:0] r_result, r_hi, r_lo;
    logic        r_valid, r_zero, r_ovf, r_halt;
    logic [31:0] w_res, w_add, w_sub;
    logic        w_ovf, w_def, w_accept, w_is_mul;

    assign valid_out = r_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_ovf;
    assign halt      = r_halt;

    assign w_add    = a + b;
    assign w_sub    = a - b;
    assign w_accept = valid_in && !busy && !r_halt;

`ifdef ALU_EXEC_FAST_MUL_EN
    logic [63:0] w_fprod;
    assign w_fprod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_is_mul = 1'b0;
    assign busy     = 1'b0;
`else
    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t      r_state;
    logic        r_busy, r_sign, r_is_mul;
    logic [5:0]  r_cnt;
    logic [31:0] r_mcand, r_mplier;
    logic [63:0] r_prod;
    logic [32:0] w_step_sum;
    logic [63:0] w_prod_fin;
    logic [31:0] w_abs_a, w_abs_b;

    assign busy       = r_busy;
    assign w_is_mul   = (ALUop == OP_MULT) || (ALUop == OP_MUL);
    assign w_abs_a    = a[31] ? (~a + 32'd1) : a;
    assign w_abs_b    = b[31] ? (~b + 32'd1) : b;
    // Partial sum enters the top half; its LSB shifts down into the low half each step.
    assign w_step_sum = {1'b0, r_prod[63:32]} + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);
    assign w_prod_fin = r_sign ? (~r_prod + 64'd1) : r_prod;
`endif

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_def = 1'b1;
        case (ALUop)
            OP_SLL:  w_res = b << shamt;
            OP_SRL:  w_res = b >> shamt;
            OP_SRA:  w_res = $signed(b) >>> shamt;
            OP_ADD: begin
                w_res = w_add;
                w_ovf = (a[31] == b[31]) && (w_add[31] != a[31]);
            end
            OP_ADDU: w_res = w_add;
            OP_SUB: begin
                w_res = w_sub;
                w_ovf = (a[31] != b[31]) && (w_sub[31] != a[31]);
            end
            OP_SUBU: w_res = w_sub;
            OP_AND:  w_res = a & b;
            OP_OR:   w_res = a | b;
            OP_XOR:  w_res = a ^ b;
            OP_NOR:  w_res = ~(a | b);
            OP_SLT:  w_res = {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: w_res = {31'd0, a < b};
            OP_LUI:  w_res = {b[15:0], 16'h0000};
            OP_MFHI: w_res = r_hi;
            OP_MFLO: w_res = r_lo;
            OP_MTHI, OP_MTLO, OP_HALT: w_res = '0;
`ifdef ALU_EXEC_FAST_MUL_EN
            OP_MULT: w_res = '0;
            OP_MUL:  w_res = w_fprod[31:0];
`endif
            default: w_def = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_halt   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifndef ALU_EXEC_FAST_MUL_EN
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_is_mul <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_result <= w_res;
                r_zero   <= w_def && (w_res == 32'd0);
                r_ovf    <= w_ovf;
                r_valid  <= 1'b1;
                if (ALUop == OP_MTHI) r_hi <= a;
                if (ALUop == OP_MTLO) r_lo <= a;
                if (ALUop == OP_HALT) r_halt <= 1'b1;
`ifdef ALU_EXEC_FAST_MUL_EN
                if (ALUop == OP_MULT) begin
                    r_hi <= w_fprod[63:32];
                    r_lo <= w_fprod[31:0];
                end
`endif
            end
`ifndef ALU_EXEC_FAST_MUL_EN
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_sign   <= a[31] ^ b[31];
                        r_is_mul <= (ALUop == OP_MUL);
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_cnt != 6'(MUL_STEPS)) begin
                        r_prod   <= {w_step_sum, r_prod[31:1]};
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 6'd1;
                    end else begin
                        if (r_is_mul) begin
                            r_result <= w_prod_fin[31:0];
                            r_zero   <= (w_prod_fin[31:0] == 32'd0);
                        end else begin
                            r_hi     <= w_prod_fin[63:32];
                            r_lo     <= w_prod_fin[31:0];
                            r_result <= '0;
                            r_zero   <= 1'b1;
                        end
                        r_ovf   <= 1'b0;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
`endif
        end
    end

endmodule
